clock_tick_gen: RTL and testbench

- Upstream timebase stage for the digital clock/display block.
- Derives two signals from the single board clock: the 1 Hz timekeeping clock and the 500 Hz digit-scan clock, each as a 50%-duty square wave plus a matching single-cycle tick enable.
- Also owns the debounced pause/run push-button and a fast-forward mode for bring-up and simulation.
- 1 Hz path can be frozen; 500 Hz scan never stops.

---
 rtl/clock_tick_gen.sv | 64 ++++++
 tb/tb_clock_tick_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/clock_tick_gen.sv
// clock_tick_gen: 1 Hz / 500 Hz square waves and tick enables, debounced pause button, fast-forward mode
module clock_tick_gen #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int FAST_FACTOR  = 10,
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic pause_btn,
   input  logic fast_en,
   output logic clk_1hz,
   output logic clk_500hz,
   output logic tick_1hz,
   output logic tick_500hz,
   output logic running
);
   localparam int HALF_500 = CLK_FREQ / 1000;
   localparam int HALF_1S  = CLK_FREQ / 2;
   localparam int HALF_1F  = CLK_FREQ / (2 * FAST_FACTOR);
   localparam int W5 = HALF_500 > 1 ? $clog2(HALF_500) : 1;
   localparam int W1 = HALF_1S > 1 ? $clog2(HALF_1S) : 1;
   localparam int WD = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [W5-1:0] T5  = W5'(HALF_500 - 1);
   localparam logic [W1-1:0] T1S = W1'(HALF_1S - 1);
   localparam logic [W1-1:0] T1F = W1'(HALF_1F - 1);
   localparam logic [WD-1:0] TD  = WD'(DEBOUNCE_CYC - 1);

   logic [W5-1:0] cnt500;
   logic [W1-1:0] cnt1;
   logic [WD-1:0] deb_cnt;
   logic sync1, sync2, deb, deb_d, wrap5, wrap1;

   // >= lets a switch into fast mode wrap on the next edge even when cnt1 is past the fast limit
   always_comb begin
      wrap5 = cnt500 == T5;
      wrap1 = cnt1 >= (fast_en ? T1F : T1S);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt500 <= '0;
         cnt1 <= '0;
         deb_cnt <= '0;
         {sync1, sync2, deb, deb_d} <= '0;
         {clk_500hz, clk_1hz, tick_500hz, tick_1hz} <= '0;
         running <= 1'b1;
      end else begin
         cnt500 <= wrap5 ? '0 : cnt500 + 1'b1;
         clk_500hz <= clk_500hz ^ wrap5;
         tick_500hz <= wrap5 && !clk_500hz;
         if (running) begin
            cnt1 <= wrap1 ? '0 : cnt1 + 1'b1;
            clk_1hz <= clk_1hz ^ wrap1;
         end
         tick_1hz <= running && wrap1 && !clk_1hz;
         sync1 <= pause_btn;
         sync2 <= sync1;
         deb_cnt <= (sync2 == deb || deb_cnt == TD) ? '0 : deb_cnt + 1'b1;
         if (sync2 != deb && deb_cnt == TD) deb <= sync2;
         deb_d <= deb;
         if (deb && !deb_d) running <= !running;
      end
   end
endmodule

// File: tb/tb_clock_tick_gen.sv
// tb_clock_tick_gen: scoreboard bench; stimulus queues expected outputs per edge, monitor checks them
module tb_clock_tick_gen;
   logic clk = 1'b0, rst = 1'b1, pause_btn = 1'b0, fast_en = 1'b0;
   logic clk_1hz, clk_500hz, tick_1hz, tick_500hz, running;
   logic [4:0] out;
   int g = 0, base = 0, n_chk = 0, n_fail = 0;

   typedef struct {
      int e;
      int k;
      logic [4:0] m;
      logic [4:0] v;
      string name;
   } exp_t;
   exp_t q[$];
   exp_t x;

   localparam logic [4:0] M_ALL = 5'b11111, M_R = 5'b10000, M_1 = 5'b00101, M_5 = 5'b01010;

   clock_tick_gen #(.CLK_FREQ(2000), .FAST_FACTOR(10), .DEBOUNCE_CYC(8)) dut (
      .clk(clk), .rst(rst), .pause_btn(pause_btn), .fast_en(fast_en),
      .clk_1hz(clk_1hz), .clk_500hz(clk_500hz), .tick_1hz(tick_1hz),
      .tick_500hz(tick_500hz), .running(running)
   );

   always #5 clk = ~clk;
   always @(posedge clk) g <= g + 1;
   assign out = {running, tick_500hz, tick_1hz, clk_500hz, clk_1hz};

   // bit order: running, tick_500hz, tick_1hz, clk_500hz, clk_1hz
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].e <= g) begin
         x = q.pop_front();
         n_chk++;
         if (x.e != g || (out & x.m) !== (x.v & x.m)) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %b required %b (mask %b)", x.name, x.k, out & x.m, x.v & x.m, x.m);
         end
      end
   end

   task automatic ex(input int k, input logic [4:0] m, input logic [4:0] v, input string nm);
      q.push_back('{base + k, k, m, v, nm});
   endtask

   task automatic wait_to(input int k);
      while (g < base + k) @(negedge clk);
   endtask

   task automatic reset_dut(input int n);
      @(negedge clk);
      rst = 1'b1;
      base = g;
      ex(n, M_ALL, 5'b10000, "reset");
      repeat (n) @(negedge clk);
      rst = 1'b0;
      base = g;
   endtask

   initial begin
      // divider timing, normal mode
      reset_dut(2);
      ex(1, M_ALL, 5'b10000, "first_edge");
      for (int k = 1; k <= 40; k++)
         ex(k, M_5, {1'b0, k % 4 == 2, 1'b0, (k / 2) % 2 == 1, 1'b0}, "div500");
      ex(999, M_R | M_1, 5'b10000, "pre_1hz_rise");
      ex(1000, M_1, 5'b00101, "1hz_rise");
      ex(1001, M_1, 5'b00001, "1hz_tick_end");
      ex(2000, M_1, 5'b00000, "1hz_fall");
      ex(2001, M_1, 5'b00000, "1hz_low");
      ex(3000, M_1, 5'b00101, "1hz_rise2");
      ex(3001, M_1, 5'b00001, "1hz_tick_end2");
      wait_to(3001);
      // fast mode from reset
      fast_en = 1'b1;
      reset_dut(2);
      ex(99, M_1, 5'b00000, "fast_pre");
      ex(100, M_1, 5'b00101, "fast_rise");
      ex(100, M_5, 5'b00000, "fast_500_a");
      ex(101, M_1, 5'b00001, "fast_tick_end");
      ex(102, M_5, 5'b01010, "fast_500_b");
      ex(200, M_1, 5'b00000, "fast_fall");
      ex(299, M_1, 5'b00000, "fast_pre2");
      ex(300, M_1, 5'b00101, "fast_rise2");
      ex(301, M_1, 5'b00001, "fast_tick_end2");
      wait_to(302);
      // switch to fast mode with cnt1 already past the fast limit
      fast_en = 1'b0;
      reset_dut(2);
      ex(500, M_1, 5'b00000, "sw_before");
      ex(501, M_1, 5'b00101, "sw_wrap");
      ex(502, M_1, 5'b00001, "sw_after");
      ex(600, M_1, 5'b00001, "sw_hold");
      ex(601, M_1, 5'b00000, "sw_fall");
      ex(700, M_1, 5'b00000, "sw_low");
      ex(701, M_1, 5'b00101, "sw_rise");
      wait_to(500);
      fast_en = 1'b1;
      wait_to(702);
      fast_en = 1'b0;
      // debounce, pause, resume from held count
      reset_dut(2);
      ex(20, M_R, 5'b10000, "bounce3");
      ex(45, M_R, 5'b10000, "bounce6");
      ex(70, M_R | M_1, 5'b10000, "pre_pause");
      ex(71, M_R, 5'b00000, "paused");
      ex(100, M_5 | M_1, 5'b00000, "scan_a");
      ex(102, M_5 | M_1, 5'b01010, "scan_b");
      ex(104, M_5 | M_1, 5'b00000, "scan_c");
      ex(210, M_R, 5'b00000, "still_paused");
      ex(211, M_R, 5'b10000, "resumed");
      ex(1000, M_R | M_1, 5'b10000, "held_no_rise");
      ex(1139, M_1, 5'b00000, "resume_pre");
      ex(1140, M_1, 5'b00101, "resume_rise");
      ex(1141, M_1, 5'b00001, "resume_tick_end");
      wait_to(10); pause_btn = 1'b1;
      wait_to(13); pause_btn = 1'b0;
      wait_to(30); pause_btn = 1'b1;
      wait_to(36); pause_btn = 1'b0;
      wait_to(60); pause_btn = 1'b1;
      wait_to(72); pause_btn = 1'b0;
      wait_to(200); pause_btn = 1'b1;
      wait_to(212); pause_btn = 1'b0;
      wait_to(1141);
      // reset mid-run
      reset_dut(2);
      ex(702, M_5 | M_1, 5'b01010, "pre_mid_reset");
      wait_to(702);
      reset_dut(1);
      ex(1, M_5, 5'b00000, "post_reset_1");
      ex(2, M_5, 5'b01010, "post_reset_2");
      ex(3, M_5, 5'b00010, "post_reset_3");
      wait_to(4);
      // pause taking effect on the terminal-count edge
      reset_dut(2);
      ex(999, M_R | M_1, 5'b10000, "tc_pre");
      ex(1000, M_R | M_1, 5'b00101, "tc_pause");
      ex(1001, M_R | M_1, 5'b00001, "tc_frozen");
      ex(2000, M_1, 5'b00001, "tc_frozen2");
      ex(3000, M_1, 5'b00001, "tc_frozen3");
      wait_to(989); pause_btn = 1'b1;
      wait_to(1001); pause_btn = 1'b0;
      wait_to(3001);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
         n_fail += q.size();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
